// File: rtl/maze_solver.sv
// Depth-first maze solver driving a 16x16 single-bit maze memory port.
// Visited cells are marked by writing 1; the found path is replayed as moves.
module maze_solver #(
  parameter logic [3:0] START_X = 4'd0,
  parameter logic [3:0] START_Y = 4'd0,
  parameter logic [3:0] GOAL_X  = 4'd15,
  parameter logic [3:0] GOAL_Y  = 4'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Start,
  output logic       RD,
  output logic       WR,
  output logic       Din,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic       Dout,
  output logic [1:0] Move,
  output logic       Move_valid,
  output logic [8:0] PathLen,
  output logic       Done,
  output logic       Fail
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_MARK, S_TRY, S_POP, S_REPLAY, S_DONE, S_FAIL
  } state_t;

  state_t     r_state;
  logic [3:0] r_cx, r_cy, r_x, r_y;
  logic [2:0] r_dir;
  logic [8:0] r_sp, r_idx, r_plen;
  logic [1:0] r_stack [0:255];
  logic [1:0] r_move;
  logic       r_rd, r_wr, r_din, r_mv, r_done, r_fail;

  // {in_bounds, nx, ny} of the neighbour in direction d; d=4 is never in bounds
  function automatic logic [8:0] probe(input logic [3:0] x, input logic [3:0] y,
                                       input logic [2:0] d);
    probe = {1'b0, x, y};
    case (d)
      3'd0: if (y != 4'd15) probe = {1'b1, x, y + 4'd1}; else probe = {1'b0, x, y};
      3'd1: if (x != 4'd15) probe = {1'b1, x + 4'd1, y}; else probe = {1'b0, x, y};
      3'd2: if (y != 4'd0)  probe = {1'b1, x, y - 4'd1}; else probe = {1'b0, x, y};
      3'd3: if (x != 4'd0)  probe = {1'b1, x - 4'd1, y}; else probe = {1'b0, x, y};
      default: probe = {1'b0, x, y};
    endcase
  endfunction

  function automatic logic [7:0] unstep(input logic [3:0] x, input logic [3:0] y,
                                        input logic [1:0] d);
    case (d)
      2'd0:    unstep = {x, y - 4'd1};
      2'd1:    unstep = {x - 4'd1, y};
      2'd2:    unstep = {x, y + 4'd1};
      default: unstep = {x + 4'd1, y};
    endcase
  endfunction

  logic [8:0] w_try, w_next, w_first, w_retry;
  logic [7:0] w_back, w_top_idx;
  logic [1:0] w_top;
  logic       w_push;

  assign w_try     = probe(r_cx, r_cy, r_dir);
  assign w_next    = probe(r_cx, r_cy, r_dir + 3'd1);
  assign w_first   = probe(r_cx, r_cy, 3'd0);
  assign w_top_idx = r_sp[7:0] - 8'd1;
  assign w_top     = r_stack[w_top_idx];
  assign w_back    = unstep(r_cx, r_cy, w_top);
  assign w_retry   = probe(w_back[7:4], w_back[3:0], {1'b0, w_top} + 3'd1);
  assign w_push    = (r_state == S_TRY) && (r_dir != 3'd4) && r_rd && !Dout;

  // Move stack; contents are only meaningful below sp, so no reset
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp[7:0]] <= r_dir[1:0];
  end

  // Search / replay FSM with registered memory-port and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cx <= 4'd0;  r_cy <= 4'd0;  r_x <= 4'd0;  r_y <= 4'd0;
      r_dir <= 3'd0; r_sp <= 9'd0;  r_idx <= 9'd0; r_plen <= 9'd0;
      r_move <= 2'd0; r_mv <= 1'b0;
      r_rd <= 1'b0;  r_wr <= 1'b0;  r_din <= 1'b0;
      r_done <= 1'b0; r_fail <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (Start) begin
            r_state <= S_CHECK;
            r_cx <= START_X; r_cy <= START_Y;
            r_x  <= START_X; r_y  <= START_Y;
            r_rd <= 1'b1;
            r_sp <= 9'd0; r_plen <= 9'd0;
            r_done <= 1'b0; r_fail <= 1'b0;
          end
        end
        S_CHECK: begin
          r_rd <= 1'b0;
          if (Dout) begin
            r_state <= S_FAIL;
            r_fail  <= 1'b1;
          end else begin
            r_state <= S_MARK;
            r_wr <= 1'b1; r_din <= 1'b1;
          end
        end
        S_MARK: begin
          r_wr <= 1'b0; r_din <= 1'b0;
          if (r_cx == GOAL_X && r_cy == GOAL_Y) begin
            r_plen <= r_sp;
            if (r_sp == 9'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_REPLAY;
              r_move  <= r_stack[0];
              r_mv    <= 1'b1;
              r_idx   <= 9'd1;
            end
          end else begin
            r_state <= S_TRY;
            r_dir <= 3'd0;
            r_rd  <= w_first[8];
            r_x   <= w_first[7:4]; r_y <= w_first[3:0];
          end
        end
        S_TRY: begin
          if (r_dir == 3'd4) begin
            r_state <= S_POP;
            r_rd <= 1'b0;
          end else if (w_push) begin
            // X/Y already address the neighbour, so MARK writes it directly
            r_state <= S_MARK;
            r_sp <= r_sp + 9'd1;
            r_cx <= w_try[7:4]; r_cy <= w_try[3:0];
            r_rd <= 1'b0; r_wr <= 1'b1; r_din <= 1'b1;
          end else begin
            r_dir <= r_dir + 3'd1;
            r_rd  <= w_next[8];
            r_x   <= w_next[7:4]; r_y <= w_next[3:0];
          end
        end
        S_POP: begin
          if (r_sp == 9'd0) begin
            r_state <= S_FAIL;
            r_fail  <= 1'b1;
          end else begin
            r_state <= S_TRY;
            r_sp  <= r_sp - 9'd1;
            r_cx  <= w_back[7:4]; r_cy <= w_back[3:0];
            r_dir <= {1'b0, w_top} + 3'd1;
            r_rd  <= w_retry[8];
            r_x   <= w_retry[7:4]; r_y <= w_retry[3:0];
          end
        end
        S_REPLAY: begin
          if (r_idx == r_sp) begin
            r_state <= S_DONE;
            r_mv <= 1'b0; r_move <= 2'd0;
            r_done <= 1'b1;
          end else begin
            r_move <= r_stack[r_idx[7:0]];
            r_idx  <= r_idx + 9'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign RD = r_rd;
  assign WR = r_wr;
  assign Din = r_din;
  assign X = r_x;
  assign Y = r_y;
  assign Move = r_move;
  assign Move_valid = r_mv;
  assign PathLen = r_plen;
  assign Done = r_done;
  assign Fail = r_fail;

endmodule

// File: tb/tb_maze_solver.sv
// Randomized self-checking bench for maze_solver with a behavioural DFS model
// and a 16x16 bit maze memory.
module tb_maze_solver;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic       rd, wr, din, dout, mvv, done, fail;
  logic       junk = 1'b0;
  logic [3:0] x, y;
  logic [1:0] mv;
  logic [8:0] plen;

  bit         mem [16][16];
  bit         pat [16][16];
  bit         ref_img [16][16];
  bit         load_req = 1'b0;
  logic [1:0] moves [$];
  logic [1:0] exp_moves [$];
  bit         exp_ok;
  int         wr_cnt = 0, din_bad = 0, excl_bad = 0;
  int         last_cycles, last_base, last_wr;
  int         n_total = 0, n_bad = 0;

  always #5 clk = ~clk;

  maze_solver dut (
    .clk(clk), .rst_n(rst_n), .Start(start), .RD(rd), .WR(wr), .Din(din),
    .X(x), .Y(y), .Dout(dout), .Move(mv), .Move_valid(mvv),
    .PathLen(plen), .Done(done), .Fail(fail)
  );

  assign dout = rd ? mem[x][y] : junk;

  always @(posedge clk) begin
    junk <= 1'($urandom_range(0, 1));
    if (load_req) mem <= pat;
    else if (wr) mem[x][y] <= 1'b1;
    if (mvv) moves.push_back(mv);
    if (wr) wr_cnt <= wr_cnt + 1;
    if (wr && !din) din_bad <= din_bad + 1;
    if (rd && wr) excl_bad <= excl_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // kind: 0 open, 1 blocked start, 2 enclosed goal, 3 dead-end, 4 random
  task automatic load_maze(input int kind);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        case (kind)
          1: pat[i][j] = (i == 0 && j == 0);
          2: pat[i][j] = (i == 14 && j == 15) || (i == 15 && j == 14);
          3: pat[i][j] = !((i == 0 && j <= 5) || j == 0 || i == 15);
          4: pat[i][j] = ($urandom_range(0, 99) < 30) && !(i == 0 && j == 0) && !(i == 15 && j == 15);
          default: pat[i][j] = 1'b0;
        endcase
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    @(negedge clk);
  endtask

  // Plain DFS over the current image, trying right, down, left, up in order
  task automatic model_solve();
    int cx, cy, nx, ny, nd;
    bit found;
    logic [1:0] d;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) ref_img[i][j] = mem[i][j];
    exp_moves.delete();
    cx = 0; cy = 0; nd = 0;
    if (ref_img[0][0]) begin exp_ok = 1'b0; return; end
    ref_img[0][0] = 1'b1;
    forever begin
      if (cx == 15 && cy == 15) begin exp_ok = 1'b1; return; end
      found = 1'b0;
      for (int k = nd; k < 4 && !found; k++) begin
        nx = cx + ((k == 1) ? 1 : (k == 3) ? -1 : 0);
        ny = cy + ((k == 0) ? 1 : (k == 2) ? -1 : 0);
        if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && !ref_img[nx][ny]) begin
          found = 1'b1;
          exp_moves.push_back(2'(k));
          ref_img[nx][ny] = 1'b1;
          cx = nx; cy = ny; nd = 0;
        end
      end
      if (!found) begin
        if (exp_moves.size() == 0) begin exp_ok = 1'b0; return; end
        d = exp_moves.pop_back();
        cx -= (d == 2'd1) ? 1 : (d == 2'd3) ? -1 : 0;
        cy -= (d == 2'd0) ? 1 : (d == 2'd2) ? -1 : 0;
        nd = int'(d) + 1;
      end
    end
  endtask

  task automatic solve_and_check(input string tag, input int inj);
    int c, nbad_mv, nbad_img, e0, d0, n;
    model_solve();
    last_base = moves.size(); last_wr = wr_cnt; e0 = excl_bad; d0 = din_bad;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (!(done || fail) && c < 12000) begin
      start = (c == inj);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    last_cycles = c;
    last_wr = wr_cnt - last_wr;
    chk({tag, ".finish"}, 32'(done | fail), 32'd1);
    chk({tag, ".done"}, 32'(done), 32'(exp_ok));
    chk({tag, ".fail"}, 32'(fail), 32'(!exp_ok));
    chk({tag, ".plen"}, 32'(plen), exp_ok ? exp_moves.size() : 0);
    n = moves.size() - last_base;
    chk({tag, ".nmoves"}, n, exp_moves.size());
    nbad_mv = 0;
    for (int i = 0; i < n && i < exp_moves.size(); i++)
      if (moves[last_base + i] != exp_moves[i]) nbad_mv++;
    chk({tag, ".moves"}, nbad_mv, 0);
    nbad_img = 0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        if (mem[i][j] != ref_img[i][j]) nbad_img++;
    chk({tag, ".image"}, nbad_img, 0);
    chk({tag, ".rdwr_excl"}, excl_bad - e0, 0);
    chk({tag, ".din"}, din_bad - d0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.outs", {rd, wr, din, x, y, mv, mvv, plen, done, fail}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    load_maze(0);
    solve_and_check("open", 0);
    chk("open.plen30", 32'(plen), 32'd30);
    chk("open.first", 32'(moves.size() > last_base ? moves[last_base] : 2'd3), 32'd0);
    chk("open.mid", 32'(moves.size() > last_base + 15 ? moves[last_base + 15] : 2'd3), 32'd1);
    chk("open.corner", 32'(mem[0][15] & mem[15][15] & mem[7][15]), 32'd1);

    load_maze(1);
    solve_and_check("blk", 0);
    chk("blk.latency", 32'(last_cycles <= 3), 32'd1);
    chk("blk.nowr", last_wr, 0);

    load_maze(2);
    solve_and_check("encl", 0);
    chk("encl.goal", 32'(mem[15][15]), 32'd0);
    chk("encl.open", 32'(mem[3][9] & mem[13][15]), 32'd1);

    load_maze(3);
    solve_and_check("dead", 0);
    chk("dead.plen30", 32'(plen), 32'd30);
    chk("dead.first", 32'(moves.size() > last_base ? moves[last_base] : 2'd3), 32'd1);
    chk("dead.mid", 32'(moves.size() > last_base + 15 ? moves[last_base + 15] : 2'd3), 32'd0);

    for (int t = 0; t < 8; t++) begin
      load_maze(4);
      solve_and_check("rand", 0);
    end

    load_maze(0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.outs", {rd, wr, din, x, y, mv, mvv, plen, done, fail}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load_maze(4);
    solve_and_check("after_rst", 0);

    load_maze(0);
    solve_and_check("busy_start", 9);
    load_maze(4);
    solve_and_check("busy_rand", 25);
    load_maze(0);
    solve_and_check("first", 0);
    solve_and_check("redo", 0);
    chk("redo.fail", 32'(fail), 32'd1);
    chk("redo.nowr", last_wr, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/maze_solver.md
Name: maze_solver

Overview:
- Initiator side of the 16x16 single-bit maze memory port (RD, WR, Din, X, Y, Dout). Drives that port to find a path from a start cell to a goal cell by depth-first search with backtracking.
- Cell value 0 = open, 1 = wall. X = row, Y = column.
- Visited cells are marked by writing 1, so the maze image is consumed by a solve.
- On success, streams the move sequence for the found path to a downstream consumer.

Parameters:
START_X, 0, start row
START_Y, 0, start column
GOAL_X, 15, goal row
GOAL_Y, 15, goal column

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
Start  input  1  one-cycle request to begin a solve; sampled only in IDLE or DONE/FAIL
RD  output  1  memory read enable
WR  output  1  memory write enable; memory writes Din at posedge
Din  output  1  memory write data; always 1 when WR=1
X  output  4  memory row address
Y  output  4  memory column address
Dout  input  1  memory read data; combinational, valid in the same cycle as RD=1, z otherwise
Move  output  2  path move: 0 right (Y+1), 1 down (X+1), 2 left (Y-1), 3 up (X-1)
Move_valid  output  1  Move valid this cycle
PathLen  output  9  number of moves in the found path
Done  output  1  held high after success until next Start
Fail  output  1  held high after no-path result until next Start

Behaviour:
- Reset (async assert): state IDLE, RD=WR=Din=0, X=Y=0, Move=0, Move_valid=0, PathLen=0, Done=Fail=0, sp=0.
- Reset mid-solve aborts immediately. Memory keeps any marks already written.
- Exclusivity: RD and WR are never high together. Dout is sampled only in cycles with RD=1.
- Internal state: cur (X,Y), dir counter 0..4, move stack of 256 x 2 bits, 9-bit sp.
- IDLE: on Start, cur <= (START_X,START_Y), clear Done/Fail/PathLen, go CHECK.
- CHECK (1 cycle): RD=1 at cur. If Dout=1, go FAIL with no write. Else go MARK.
- MARK (1 cycle): WR=1, Din=1 at cur.
  - If cur == goal: PathLen <= sp, replay index <= 0, go REPLAY (or DONE if sp=0).
  - Else dir <= 0, go TRY.
- TRY (1 cycle per direction):
  - If dir=4, go POP.
  - Otherwise compute the neighbour for dir. If the neighbour is out of bounds (wrap is never allowed), dir++ with RD=0.
  - Else RD=1 at the neighbour. Dout=0: push dir, sp++, cur <= neighbour, go MARK. Dout=1 (wall or visited): dir++.
- POP (1 cycle):
  - If sp=0, go FAIL.
  - Else sp--, d <= stack[sp-1], cur <= cur minus step(d), dir <= d+1, go TRY.
  - When d=3, dir becomes 4, which causes an immediate further POP from TRY.
- REPLAY: one move per cycle. Move=stack[i], Move_valid=1, i = 0..sp-1. After the last move, go DONE. There is no backpressure.
- DONE: Done=1, RD=WR=0. FAIL: Fail=1, RD=WR=0.
- Start in DONE/FAIL begins a new solve on the current (already marked) memory image.
- Start in any busy state is ignored.
- Stack capacity 256 is sufficient (path ≤ 255 moves); overflow is impossible.
- Start == goal: succeeds after MARK with PathLen=0 and no Move_valid pulses.

Test Plan:
- All-zero maze, Start pulse -> REPLAY emits 15 x Move=0 then 15 x Move=1, PathLen=30, Done=1. Cells (0,0..15) and (1..15,15) read back 1.
- Memory(0,0)=1, Start -> Fail=1 within 3 cycles of Start, WR never asserted, Done=0.
- Goal enclosed (cells (14,15),(15,14) =1, rest 0), Start -> Fail=1. Every open cell except (15,15) reads back 1. No Move_valid pulses.
- Dead-end maze: row 0 open Y=0..5, with (1,5) and (0,6) walls; column 0 open to X=15; row 15 open to Y=15; all other cells walls -> PathLen=30. Moves are 15 x 1 then 15 x 0. None of the dead-end moves appear in the output.
- Assert rst_n=0 for 1 cycle during TRY -> all outputs 0 immediately, RD=WR=0. New Start on a fresh maze solves correctly.
- Start pulsed during TRY/POP -> ignored, solve result unchanged. Start pulsed in DONE -> new solve on the marked image; start cell now 1 -> Fail.
